skill_scheduler: RTL and testbench

Two-player scheduler for the shared teleport skill datapath. It latches skill requests from both players, arbitrates between them, and drives the datapath's state code, holding it long enough for the registered ball position to settle. It then pulses the ball-load strobe and enforces per-player cooldowns and per-point use limits. It sits between the player input decoders and the teleport datapath / ball physics.

---
 rtl/skill_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_skill_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skill_scheduler.sv
// skill_scheduler: two-player arbiter for the shared teleport skill datapath.
//
// Latches rising-edge skill requests from both players, picks a winner
// (round-robin on ties), holds the datapath state code at 1 for ARM_CYCLES so
// the registered ball position settles, then strobes load_ball for one cycle.
// Afterwards the owner is blocked for COOLDOWN cycles.
//
// Optional feature macro: SKILL_USE_LIMIT_EN
//   defined   -> each player may teleport at most MAX_USES times per point
//   undefined -> uses are unlimited; MAX_USES is ignored
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   req_p1/p2    player skill buttons (level; rising edge = request)
//   game_active  rally in progress
//   point_end    one-cycle pulse when a point is scored
//   skill_state  datapath state code: 1 = teleport active, 0 = idle
//   load_ball    one-cycle strobe to ball physics
//   owner        01 = p1, 10 = p2, 00 = none (valid ARM through LOAD)
//   busy         FSM not idle
//   cd_p1/cd_p2  player cooldown counter nonzero
module skill_scheduler #(
    parameter int unsigned COOLDOWN   = 50000000,
    parameter int unsigned CD_W       = 27,
    parameter int unsigned ARM_CYCLES = 2,
    parameter int unsigned MAX_USES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_p1,
    input  logic       req_p2,
    input  logic       game_active,
    input  logic       point_end,
    output logic [3:0] skill_state,
    output logic       load_ball,
    output logic [1:0] owner,
    output logic       busy,
    output logic       cd_p1,
    output logic       cd_p2
);

    localparam int unsigned ArmW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StArm, StLoad} state_e;

    state_e            state_q, state_d;
    logic [1:0]        req_d_q;
    logic [1:0]        rise;
    logic [1:0]        pending_q, pending_d;
    logic [1:0]        owner_q, owner_d;
    logic              last_p2_q, last_p2_d;  // 1: p2 won the last grant
    logic [ArmW-1:0]   arm_cnt_q, arm_cnt_d;
    logic [CD_W-1:0]   cd_q [2];
    logic [CD_W-1:0]   cd_d [2];
    logic [1:0]        cd_zero;
    logic [1:0]        use_ok;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              load_done;

    // Bit 0 is player 1, bit 1 is player 2 throughout.
    assign rise = {req_p2, req_p1} & ~req_d_q;

`ifdef SKILL_USE_LIMIT_EN
    localparam int unsigned UseW = $clog2(MAX_USES + 1);

    logic [UseW-1:0] uses_q [2];
    logic [UseW-1:0] uses_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            use_ok[i] = uses_q[i] < UseW'(MAX_USES);
            uses_d[i] = uses_q[i];
            if (load_done && owner_q[i]) begin
                uses_d[i] = uses_q[i] + 1'b1;
            end
            if (point_end) begin
                uses_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                uses_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                uses_q[i] <= uses_d[i];
            end
        end
    end
`else
    assign use_ok = 2'b11;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cd_zero[i]  = (cd_q[i] == '0);
            // A grant is never issued on a point_end cycle; that cycle wipes all requests.
            eligible[i] = pending_q[i] & game_active & cd_zero[i] & use_ok[i] & ~point_end;
        end
    end

    // FSM next state, owner and round-robin bookkeeping.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_p2_d = last_p2_q;
        arm_cnt_d = arm_cnt_q;
        grant     = 2'b00;
        load_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (eligible == 2'b11) begin
                    grant = last_p2_q ? 2'b01 : 2'b10;
                end else begin
                    grant = eligible;
                end
                if (grant != 2'b00) begin
                    owner_d   = grant;
                    last_p2_d = grant[1];
                    arm_cnt_d = '0;
                    state_d   = StArm;
                end
            end
            StArm: begin
                if (!game_active || point_end) begin
                    owner_d = 2'b00;
                    state_d = StIdle;
                end else if (arm_cnt_q == ArmW'(ARM_CYCLES - 1)) begin
                    state_d = StLoad;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            StLoad: begin
                // Committed: completes even if game_active drops or the point ends.
                load_done = 1'b1;
                owner_d   = 2'b00;
                state_d   = StIdle;
            end
            default: begin
                owner_d = 2'b00;
                state_d = StIdle;
            end
        endcase
    end

    // Pending flags and cooldown counters.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pending_d[i] = pending_q[i];
            // The current owner cannot queue a second request behind itself.
            if (rise[i] && game_active && cd_zero[i] && use_ok[i] &&
                !(busy && owner_q[i])) begin
                pending_d[i] = 1'b1;
            end
            if (grant[i] || point_end) begin
                pending_d[i] = 1'b0;
            end

            cd_d[i] = cd_zero[i] ? cd_q[i] : cd_q[i] - 1'b1;
            if (load_done && owner_q[i]) begin
                cd_d[i] = CD_W'(COOLDOWN);
            end
            if (point_end) begin
                cd_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            req_d_q   <= 2'b00;
            pending_q <= 2'b00;
            owner_q   <= 2'b00;
            last_p2_q <= 1'b1;
            arm_cnt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            req_d_q   <= {req_p2, req_p1};
            pending_q <= pending_d;
            owner_q   <= owner_d;
            last_p2_q <= last_p2_d;
            arm_cnt_q <= arm_cnt_d;
            for (int i = 0; i < 2; i++) begin
                cd_q[i] <= cd_d[i];
            end
        end
    end

    assign busy        = (state_q != StIdle);
    assign skill_state = busy ? 4'd1 : 4'd0;
    assign load_ball   = (state_q == StLoad);
    assign owner       = owner_q;
    assign cd_p1       = ~cd_zero[0];
    assign cd_p2       = ~cd_zero[1];

endmodule

// File: tb/tb_skill_scheduler.sv
// tb_skill_scheduler: directed self-checking bench for skill_scheduler
// (COOLDOWN=10, ARM_CYCLES=2, MAX_USES=2). Inputs change 1 time unit after a
// rising clock edge; outputs are sampled at that same point.
module tb_skill_scheduler;

    localparam int unsigned COOLDOWN   = 10;
    localparam int unsigned CD_W       = 4;
    localparam int unsigned ARM_CYCLES = 2;
    localparam int unsigned MAX_USES   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_p1;
    logic       req_p2;
    logic       game_active;
    logic       point_end;
    logic [3:0] skill_state;
    logic       load_ball;
    logic [1:0] owner;
    logic       busy;
    logic       cd_p1;
    logic       cd_p2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    skill_scheduler #(
        .COOLDOWN   (COOLDOWN),
        .CD_W       (CD_W),
        .ARM_CYCLES (ARM_CYCLES),
        .MAX_USES   (MAX_USES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_p1      (req_p1),
        .req_p2      (req_p2),
        .game_active (game_active),
        .point_end   (point_end),
        .skill_state (skill_state),
        .load_ball   (load_ball),
        .owner       (owner),
        .busy        (busy),
        .cd_p1       (cd_p1),
        .cd_p2       (cd_p2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] s, input logic l,
                              input logic [1:0] o, input logic b);
        check({tag, ".skill_state"}, 32'(skill_state), 32'(s));
        check({tag, ".load_ball"}, 32'(load_ball), 32'(l));
        check({tag, ".owner"}, 32'(owner), 32'(o));
        check({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_point_end();
        point_end = 1'b1;
        tick(1);
        point_end = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_p1 = 1'b0;
        req_p2 = 1'b0;
        game_active = 1'b0;
        point_end = 1'b0;
        #12;
        expect_out("reset", 4'd0, 1'b0, 2'b00, 1'b0);
        check("reset.cd_p1", 32'(cd_p1), 32'd0);
        check("reset.cd_p2", 32'(cd_p2), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        game_active = 1'b1;
        tick(1);

        // Tie straight after reset: p1 first, p2 on the next IDLE.
        req_p1 = 1'b1;
        req_p2 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        req_p2 = 1'b0;
        check("tie1.e0.busy", 32'(busy), 32'd0);
        tick(1);
        expect_out("tie1.e1", 4'd1, 1'b0, 2'b01, 1'b1);
        tick(2);
        expect_out("tie1.e3", 4'd1, 1'b1, 2'b01, 1'b1);
        tick(1);
        expect_out("tie1.e4", 4'd0, 1'b0, 2'b00, 1'b0);
        check("tie1.e4.cd_p1", 32'(cd_p1), 32'd1);
        tick(1);
        expect_out("tie1.e5", 4'd1, 1'b0, 2'b10, 1'b1);
        tick(2);
        expect_out("tie1.e7", 4'd1, 1'b1, 2'b10, 1'b1);
        tick(1);
        expect_out("tie1.e8", 4'd0, 1'b0, 2'b00, 1'b0);
        check("tie1.e8.cd_p2", 32'(cd_p2), 32'd1);
        tick(10);
        check("tie1.e18.cd_p1", 32'(cd_p1), 32'd0);
        check("tie1.e18.cd_p2", 32'(cd_p2), 32'd0);
        pulse_point_end();

        // Single p1 request with full latency and 10-cycle cooldown.
        req_p1 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        check("single.e0.busy", 32'(busy), 32'd0);
        tick(1);
        expect_out("single.e1", 4'd1, 1'b0, 2'b01, 1'b1);
        tick(1);
        expect_out("single.e2", 4'd1, 1'b0, 2'b01, 1'b1);
        tick(1);
        expect_out("single.e3", 4'd1, 1'b1, 2'b01, 1'b1);
        tick(1);
        expect_out("single.e4", 4'd0, 1'b0, 2'b00, 1'b0);
        check("single.e4.cd_p1", 32'(cd_p1), 32'd1);

        // Re-request during cooldown is dropped, not queued.
        tick(2);
        req_p1 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        check("cddrop.e7.busy", 32'(busy), 32'd0);
        tick(6);
        check("cddrop.e13.cd_p1", 32'(cd_p1), 32'd1);
        tick(1);
        check("cddrop.e14.cd_p1", 32'(cd_p1), 32'd0);
        tick(1);
        check("cddrop.e15.busy", 32'(busy), 32'd0);
        req_p1 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        tick(1);
        expect_out("cdok.e1", 4'd1, 1'b0, 2'b01, 1'b1);
        tick(3);
        check("cdok.e4.cd_p1", 32'(cd_p1), 32'd1);
        tick(11);
        check("cdok.cd_expired", 32'(cd_p1), 32'd0);
        pulse_point_end();

        // Tie after p1 won last: p2 first this time.
        req_p1 = 1'b1;
        req_p2 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        req_p2 = 1'b0;
        tick(1);
        expect_out("tie2.e1", 4'd1, 1'b0, 2'b10, 1'b1);
        tick(3);
        check("tie2.e4.busy", 32'(busy), 32'd0);
        tick(1);
        expect_out("tie2.e5", 4'd1, 1'b0, 2'b01, 1'b1);
        tick(3);
        check("tie2.e8.busy", 32'(busy), 32'd0);
        tick(11);
        check("tie2.cd_p1", 32'(cd_p1), 32'd0);
        check("tie2.cd_p2", 32'(cd_p2), 32'd0);
        pulse_point_end();

        // game_active drop during ARM aborts with no load and no cooldown.
        req_p1 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        tick(1);
        expect_out("abort.e1", 4'd1, 1'b0, 2'b01, 1'b1);
        game_active = 1'b0;
        tick(1);
        expect_out("abort.e2", 4'd0, 1'b0, 2'b00, 1'b0);
        tick(1);
        check("abort.e3.load_ball", 32'(load_ball), 32'd0);
        check("abort.e3.cd_p1", 32'(cd_p1), 32'd0);
        game_active = 1'b1;
        tick(1);

        // point_end during LOAD: load completes, no cooldown, p2 pending wiped.
        req_p1 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        tick(1);
        req_p2 = 1'b1;
        tick(1);
        req_p2 = 1'b0;
        tick(1);
        expect_out("pe_load.e3", 4'd1, 1'b1, 2'b01, 1'b1);
        point_end = 1'b1;
        tick(1);
        point_end = 1'b0;
        expect_out("pe_load.e4", 4'd0, 1'b0, 2'b00, 1'b0);
        check("pe_load.e4.cd_p1", 32'(cd_p1), 32'd0);
        tick(1);
        check("pe_load.e5.busy", 32'(busy), 32'd0);
        tick(1);
        check("pe_load.e6.busy", 32'(busy), 32'd0);

`ifdef SKILL_USE_LIMIT_EN
        // Two uses allowed per point; the third is dropped until point_end.
        for (int k = 0; k < 2; k++) begin
            req_p1 = 1'b1;
            tick(1);
            req_p1 = 1'b0;
            tick(1);
            check("limit.grant", 32'(owner), 32'b01);
            tick(3 + 11);
        end
        req_p1 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        tick(1);
        check("limit.third.busy", 32'(busy), 32'd0);
        tick(2);
        check("limit.third.busy2", 32'(busy), 32'd0);
        pulse_point_end();
        req_p1 = 1'b1;
        tick(1);
        req_p1 = 1'b0;
        tick(1);
        expect_out("limit.after_pe", 4'd1, 1'b0, 2'b01, 1'b1);
        tick(4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
